mem_arbiter: RTL



---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/bus_watchdog.sv | 37 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants for the native-bus arbiter: bus widths, the default
// rdata returned on a timed-out transfer, and the arbiter state encoding.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts owned cycles without an acknowledge and
// flags the cycle on which the owner must be completed with an error.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);
    import mem_bus_pkg::*;

    localparam int               TC_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TC     = TC_INT[CNT_W-1:0];
    localparam logic             ENABLE = (TIMEOUT > 0);

    logic [CNT_W-1:0] cnt;

    // Clear when a new ownership begins; saturate at the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (active && !ack && (cnt != TC)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A late ack on the terminal cycle is still a normal completion.
    always_comb begin
        expired = ENABLE && active && !ack && (cnt == TC);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with
// per-transaction locking and a watchdog that completes stuck transfers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; s_* driven to 0; arbitrates pending requests
// OWN0    | master 0 owns the bus; s_* follow m0_*, ready/rdata return
// OWN1    | master 1 owns the bus; s_* follow m1_*, ready/rdata return
module mem_arbiter #(
    parameter int                ADDR_W   = mem_bus_pkg::ADDR_W,
    parameter int                DATA_W   = mem_bus_pkg::DATA_W,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = mem_bus_pkg::ERR_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                err,
    output logic                err_master,
    input  logic                err_clr
);
    import mem_bus_pkg::*;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       last;
    logic       start;
    logic       owner_valid;
    logic       timeout;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .active  (owner_valid),
        .ack     (s_ready),
        .expired (timeout)
    );

    // Request of whichever master currently owns the bus.
    always_comb begin
        owner_valid = 1'b0;
        if (state == ST_OWN0) owner_valid = m0_valid;
        if (state == ST_OWN1) owner_valid = m1_valid;
    end

    // Next state: round-robin pick in IDLE; any end of ownership returns to IDLE.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                start = m0_valid | m1_valid;
                if (m0_valid && m1_valid) state_nx = last ? ST_OWN0 : ST_OWN1;
                else if (m0_valid)        state_nx = ST_OWN0;
                else if (m1_valid)        state_nx = ST_OWN1;
            end
            ST_OWN0: if (!m0_valid || s_ready || timeout) state_nx = ST_IDLE;
            ST_OWN1: if (!m1_valid || s_ready || timeout) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Last-served pointer, updated on normal or forced completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (m0_ready) begin
            last <= 1'b0;
        end else if (m1_ready) begin
            last <= 1'b1;
        end
    end

    // Sticky error flag; a timeout outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_master <= 1'b0;
        end else if (timeout) begin
            err        <= 1'b1;
            err_master <= (state == ST_OWN1);
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Downstream and return-path muxing for the current owner.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state)
            ST_OWN0: begin
                s_valid  = m0_valid & ~timeout;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = m0_valid & (s_ready | timeout);
                m0_rdata = timeout ? ERR_DATA : s_rdata;
            end
            ST_OWN1: begin
                s_valid  = m1_valid & ~timeout;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = m1_valid & (s_ready | timeout);
                m1_rdata = timeout ? ERR_DATA : s_rdata;
            end
            default: ;
        endcase
    end

    // Owner indication follows the registered state.
    always_comb begin
        grant = {state == ST_OWN1, state == ST_OWN0};
    end

endmodule
